// File: rtl/mips32_bus_pkg.sv
// Shared types and constants for the MIPS32 data-bus fabric.
package mips32_bus_pkg;

    localparam int MAX_SLAVES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } bus_state_t;

    // Binary slave-index width; at least one bit even for a single slave.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mips32_bus_region_dec.sv
// Combinational address-region decoder: hit flag, one-hot select and binary
// index, with the lowest-index region winning when regions overlap.
module mips32_bus_region_dec
    import mips32_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 32,
    localparam int IDX_W     = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [NUM_SLAVES*ADDR_W-1:0] base_i,
    input  logic [NUM_SLAVES*ADDR_W-1:0] mask_i,
    output logic                         hit_o,
    output logic [NUM_SLAVES-1:0]        sel_o,
    output logic [IDX_W-1:0]             idx_o
);

    logic [NUM_SLAVES-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign match[gi] = (addr_i & ~mask_i[gi*ADDR_W +: ADDR_W])
                               == base_i[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o    = 1'b1;
                sel_o    = '0;
                sel_o[i] = 1'b1;
                idx_o    = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mips32_bus_fabric.sv
// Multi-cycle data-bus interconnect between the MIPS32 datapath and N slaves.
// Define MIPS32_BUS_TIMEOUT_EN to abort accesses that are not acked in time.
module mips32_bus_fabric
    import mips32_bus_pkg::*;
#(
    parameter int NUM_SLAVES  = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
        {32'h7FFF0000, 32'hB8000000, 32'h10010000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK =
        {32'h0000FFFF, 32'h00001FFF, 32'h00001FFF},
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic [DATA_W/8-1:0]          cpu_be,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    output logic                         cpu_err,
    output logic [NUM_SLAVES-1:0]        s_en,
    output logic [DATA_W/8-1:0]          s_be,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack
);

    localparam int IDX_W = idx_width(NUM_SLAVES);

    bus_state_t              state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [NUM_SLAVES-1:0]   s_en_q;
    logic [DATA_W/8-1:0]     s_be_q;
    logic [ADDR_W-1:0]       s_addr_q;
    logic [DATA_W-1:0]       s_wdata_q;
    logic [DATA_W-1:0]       cpu_rdata_q;
    logic                    cpu_ready_q;
    logic                    cpu_err_q;

    logic                    dec_hit;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic [IDX_W-1:0]        dec_idx;

    logic [ADDR_W-1:0]       mask_arr  [NUM_SLAVES];
    logic [DATA_W-1:0]       rdata_arr [NUM_SLAVES];
    logic                    ack_sel_d;
    logic [DATA_W-1:0]       rdata_sel_d;

    mips32_bus_region_dec #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W)
    ) u_dec (
        .addr_i (cpu_addr),
        .base_i (SLV_BASE),
        .mask_i (SLV_MASK),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel),
        .idx_o  (dec_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slice
            assign mask_arr[gi]  = SLV_MASK[gi*ADDR_W +: ADDR_W];
            assign rdata_arr[gi] = s_rdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Only the latched slave's ack and data are ever looked at.
    assign ack_sel_d   = s_ack[idx_q];
    assign rdata_sel_d = rdata_arr[idx_q];

`ifdef MIPS32_BUS_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            s_en_q      <= '0;
            s_be_q      <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_err_q   <= 1'b0;
`ifdef MIPS32_BUS_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        s_addr_q  <= cpu_addr & mask_arr[dec_idx];
                        s_be_q    <= cpu_be;
                        s_wdata_q <= cpu_wdata;
                        idx_q     <= dec_idx;
                        if (dec_hit) begin
                            s_en_q  <= dec_sel;
                            state_q <= ACCESS;
`ifdef MIPS32_BUS_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end else begin
                            cpu_rdata_q <= '0;
                            cpu_ready_q <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            state_q     <= ERROR;
                        end
                    end
                end
                ACCESS: begin
                    if (ack_sel_d) begin
                        cpu_rdata_q <= rdata_sel_d;
                        s_en_q      <= '0;
                        cpu_ready_q <= 1'b1;
                        cpu_err_q   <= 1'b0;
                        state_q     <= DONE;
                    end
`ifdef MIPS32_BUS_TIMEOUT_EN
                    // Last allowed wait cycle: abort unless the ack above won.
                    else if (tmo_q == TMO_LAST) begin
                        cpu_rdata_q <= '0;
                        s_en_q      <= '0;
                        cpu_ready_q <= 1'b1;
                        cpu_err_q   <= 1'b1;
                        state_q     <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                DONE, ERROR: begin
                    cpu_ready_q <= 1'b0;
                    cpu_err_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_err   = cpu_err_q;
    assign s_en      = s_en_q;
    assign s_be      = s_be_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;

endmodule

// File: tb/tb_mips32_bus_fabric.sv
// Directed self-checking bench for mips32_bus_fabric (3 slaves, 32-bit bus).
module tb_mips32_bus_fabric;

    localparam int NS = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           cpu_req;
    logic [3:0]     cpu_be;
    logic [31:0]    cpu_addr;
    logic [31:0]    cpu_wdata;
    logic [31:0]    cpu_rdata;
    logic           cpu_ready;
    logic           cpu_err;
    logic [NS-1:0]  s_en;
    logic [3:0]     s_be;
    logic [31:0]    s_addr;
    logic [31:0]    s_wdata;
    logic [NS*32-1:0] s_rdata;
    logic [NS-1:0]  s_ack;

    int n_cmp = 0;
    int n_err = 0;

    mips32_bus_fabric #(
        .NUM_SLAVES  (NS),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .s_en      (s_en),
        .s_be      (s_be),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ack     (s_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_be = '0; cpu_addr = '0;
        cpu_wdata = '0; s_rdata = '0; s_ack = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_s_en",   32'(s_en), 32'h0);
        chk("rst_ready",  32'(cpu_ready), 32'h0);
        chk("rst_err",    32'(cpu_err), 32'h0);
        chk("rst_rdata",  cpu_rdata, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_be",   32'(s_be), 32'h0);
        chk("rst_wdata",  s_wdata, 32'h0);

        // Zero-wait read from slave0
        cpu_req = 1'b1; cpu_addr = 32'h10010008; cpu_be = 4'b0000;
        s_rdata[31:0] = 32'hDEADBEEF;
        tick();
        cpu_req = 1'b0;
        chk("zw_s_en",   32'(s_en), 32'h1);
        chk("zw_s_addr", s_addr, 32'h0008);
        chk("zw_ready0", 32'(cpu_ready), 32'h0);
        s_ack = 3'b001;
        tick();
        s_ack = '0;
        chk("zw_ready",  32'(cpu_ready), 32'h1);
        chk("zw_rdata",  cpu_rdata, 32'hDEADBEEF);
        chk("zw_err",    32'(cpu_err), 32'h0);
        chk("zw_s_en_off", 32'(s_en), 32'h0);
        tick();
        chk("zw_ready_pulse", 32'(cpu_ready), 32'h0);

        // Write to slave1 with three wait states
        cpu_req = 1'b1; cpu_addr = 32'hB8000104; cpu_be = 4'b0011;
        cpu_wdata = 32'h00004141; s_rdata[63:32] = 32'h12345678;
        tick();
        cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ws_s_en_c%0d", k + 1), 32'(s_en), 32'h2);
            chk($sformatf("ws_ready_c%0d", k + 1), 32'(cpu_ready), 32'h0);
            if (k == 0) begin
                chk("ws_s_addr", s_addr, 32'h0104);
                chk("ws_s_be",   32'(s_be), 32'h3);
                chk("ws_wdata",  s_wdata, 32'h00004141);
            end
            if (k == 3) s_ack = 3'b010;
            tick();
        end
        s_ack = '0;
        chk("ws_ready", 32'(cpu_ready), 32'h1);
        chk("ws_err",   32'(cpu_err), 32'h0);
        chk("ws_rdata", cpu_rdata, 32'h12345678);
        tick();

        // Decode miss
        cpu_req = 1'b1; cpu_addr = 32'h00000000; cpu_be = '0;
        tick();
        cpu_req = 1'b0;
        chk("miss_s_en",  32'(s_en), 32'h0);
        chk("miss_ready", 32'(cpu_ready), 32'h1);
        chk("miss_err",   32'(cpu_err), 32'h1);
        chk("miss_rdata", cpu_rdata, 32'h0);
        tick();
        chk("miss_ready_off", 32'(cpu_ready), 32'h0);
        chk("miss_err_off",   32'(cpu_err), 32'h0);

        // Spurious acks in IDLE and from a non-selected slave
        s_ack = 3'b111;
        tick();
        s_ack = '0;
        chk("sp_idle_ready", 32'(cpu_ready), 32'h0);
        chk("sp_idle_s_en",  32'(s_en), 32'h0);
        cpu_req = 1'b1; cpu_addr = 32'h10010010; s_rdata[31:0] = 32'hCAFEF00D;
        s_rdata[95:64] = 32'h55555555;
        tick();
        cpu_req = 1'b0;
        s_ack = 3'b100;
        tick();
        chk("sp_s_en_a", 32'(s_en), 32'h1);
        chk("sp_ready_a", 32'(cpu_ready), 32'h0);
        tick();
        chk("sp_s_en_b", 32'(s_en), 32'h1);
        s_ack = 3'b001;
        tick();
        s_ack = '0;
        chk("sp_ready", 32'(cpu_ready), 32'h1);
        chk("sp_rdata", cpu_rdata, 32'hCAFEF00D);
        tick();

        // Request and ack held high: one access per three cycles, unaligned offset
        cpu_req = 1'b1; cpu_addr = 32'h7FFF1235; s_ack = 3'b100;
        tick();
        chk("bb_s_en1",  32'(s_en), 32'h4);
        chk("bb_s_addr", s_addr, 32'h1235);
        tick();
        chk("bb_ready1", 32'(cpu_ready), 32'h1);
        chk("bb_rdata",  cpu_rdata, 32'h55555555);
        tick();
        chk("bb_idle_s_en",  32'(s_en), 32'h0);
        chk("bb_idle_ready", 32'(cpu_ready), 32'h0);
        tick();
        chk("bb_s_en2", 32'(s_en), 32'h4);
        tick();
        cpu_req = 1'b0; s_ack = '0;
        chk("bb_ready2", 32'(cpu_ready), 32'h1);
        tick();

        // Reset in the second ACCESS cycle
        cpu_req = 1'b1; cpu_addr = 32'h10010020;
        tick();
        cpu_req = 1'b0;
        tick();
        chk("rm_s_en_pre", 32'(s_en), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rm_s_en",  32'(s_en), 32'h0);
        chk("rm_ready", 32'(cpu_ready), 32'h0);
        s_ack = 3'b001;
        tick();
        chk("rm_late_ready", 32'(cpu_ready), 32'h0);
        chk("rm_late_s_en",  32'(s_en), 32'h0);
        tick();
        s_ack = '0;
        chk("rm_late_ready2", 32'(cpu_ready), 32'h0);

`ifdef MIPS32_BUS_TIMEOUT_EN
        // Slave that never acks aborts after four ACCESS cycles
        cpu_req = 1'b1; cpu_addr = 32'hB8000010;
        tick();
        cpu_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to_s_en_c%0d", k + 1), 32'(s_en), 32'h2);
            tick();
        end
        chk("to_s_en_off", 32'(s_en), 32'h0);
        chk("to_ready",    32'(cpu_ready), 32'h1);
        chk("to_err",      32'(cpu_err), 32'h1);
        chk("to_rdata",    cpu_rdata, 32'h0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
